// File: rtl/uart_rx_core_if.sv
// Receive-side byte handshake between the UART receiver and its consumer.
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    // Receiver side: produces bytes and status, observes consumer ready.
    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready
    );

    // Consumer side.
    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8-N-1 UART receiver: 2-FF input sync, 16x oversample tick, majority-voted
// bit sampling, valid/ready byte delivery with framing-error and overrun pulses.
module uart_rx_core #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rxd,
    uart_rx_core_if.master rx
);

    // Rounded divider from clk to the oversample tick.
    localparam int DIV = (CLK_HZ + BAUD * (OVERSAMPLE / 2)) / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;
    logic          sync1_q, sync2_q;
    logic [2:0]    hist_q;
    logic [DW-1:0] div_q;
    logic          tick;
    logic          rxs;
    logic          maj;
    logic          good;

    assign rxs  = sync2_q;
    assign tick = (div_q == DW'(DIV - 1));
    assign maj  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    // Free-running oversample divider; tick on the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + DW'(1);
    end

    // Three most recent tick samples feed the majority vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    hist_q <= 3'b000;
        else if (tick) hist_q <= {hist_q[1:0], rxs};
    end

    // FSM and output state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_IDLE;
            cnt_q   <= 4'd0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    // Next-state: frame decoding on ticks, handshake/delivery every clock.
    // WAIT_IDLE reuses cnt to count consecutive high samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        good    = 1'b0;

        if (valid_q && rx.rx_ready) valid_d = 1'b0;

        if (tick) begin
            case (state_q)
                WAIT_IDLE: begin
                    if (!rxs) cnt_d = 4'd0;
                    else if (cnt_q == 4'd15) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else cnt_d = cnt_q + 4'd1;
                end
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        cnt_d   = 4'd0;
                    end
                end
                START: begin
                    if (cnt_q == 4'd7) begin
                        if (rxs) state_d = IDLE;   // glitch, not a start bit
                        else begin
                            state_d = DATA;
                            cnt_d   = 4'd0;
                            bit_d   = 3'd0;
                        end
                    end else cnt_d = cnt_q + 4'd1;
                end
                DATA: begin
                    if (cnt_q == 4'd15) begin
                        sh_d  = {maj, sh_q[7:1]};
                        cnt_d = 4'd0;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = STOP;
                    end else cnt_d = cnt_q + 4'd1;
                end
                STOP: begin
                    if (cnt_q == 4'd15) begin
                        cnt_d = 4'd0;
                        if (maj) begin
                            state_d = IDLE;      // mid stop bit: ready for next start
                            good    = 1'b1;
                        end else begin
                            state_d = WAIT_IDLE; // resync before trusting the line
                            fe_d    = 1'b1;
                        end
                    end else cnt_d = cnt_q + 4'd1;
                end
                default: state_d = WAIT_IDLE;
            endcase
        end

        // A byte loads if the holding register is free or being drained now.
        if (good) begin
            if (!valid_q || rx.rx_ready) begin
                data_d  = sh_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.frame_err = fe_q;
    assign rx.overrun   = ov_q;
    assign rx.busy      = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + random frames for uart_rx_core at DIV=1 (16 clk per bit).
module tb_uart_rx_core;

    logic clk = 1'b0;
    logic rst_n;
    logic rxd;

    uart_rx_core_if bus();

    uart_rx_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .rx    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observations gathered on the falling edge, away from the active edge.
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int n_fe   = 0;
    int n_ov   = 0;
    int n_both = 0;
    int n_vld  = 0;
    int n_busy = 0;

    always @(negedge clk) begin
        if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
        if (bus.frame_err) n_fe++;
        if (bus.overrun) n_ov++;
        if (bus.frame_err && bus.overrun) n_both++;
        if (bus.rx_valid) n_vld++;
        if (bus.busy) n_busy++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bit time = 16 clocks at DIV=1.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        clks(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            clks(16);
        end
        rxd = stop_bit;
        clks(16);
        rxd = 1'b1;
    endtask

    // Compare everything received against the model's expected stream.
    task automatic check_stream(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int fe0, ov0, vld0, busy0;
        logic [7:0] r;

        rxd         = 1'b1;
        bus.rx_ready = 1'b1;
        rst_n       = 1'b0;
        clks(3);
        chk("reset_outputs", {bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.busy}, 32'd0);
        rst_n = 1'b1;
        clks(20);
        chk("wait_idle_busy", bus.busy, 1'b0);

        // Single byte, consumer always ready.
        fe0 = n_fe; ov0 = n_ov; vld0 = n_vld;
        send_byte(8'hA5, 1'b1); exp_q.push_back(8'hA5);
        clks(8);
        check_stream("a5");
        chk("a5_valid_width", n_vld - vld0, 1);
        chk("a5_flags", (n_fe - fe0) + (n_ov - ov0), 0);

        // Back-to-back frames with a single stop bit.
        fe0 = n_fe; ov0 = n_ov;
        send_byte(8'h3C, 1'b1); exp_q.push_back(8'h3C);
        send_byte(8'hFF, 1'b1); exp_q.push_back(8'hFF);
        send_byte(8'h00, 1'b1); exp_q.push_back(8'h00);
        clks(8);
        check_stream("b2b");
        chk("b2b_flags", (n_fe - fe0) + (n_ov - ov0), 0);

        // Random bytes with random idle gaps.
        for (int k = 0; k < 5; k++) begin
            r = 8'($urandom);
            send_byte(r, 1'b1);
            exp_q.push_back(r);
            clks($urandom_range(0, 20));
        end
        clks(8);
        check_stream("rand");

        // Overrun: consumer stalled across two frames.
        bus.rx_ready = 1'b0;
        ov0 = n_ov; fe0 = n_fe;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        clks(4);
        chk("ovr_valid", bus.rx_valid, 1'b1);
        chk("ovr_data", bus.rx_data, 8'h11);
        chk("ovr_pulses", n_ov - ov0, 1);
        chk("ovr_no_fe", n_fe - fe0, 0);
        bus.rx_ready = 1'b1;
        clks(1);
        chk("ovr_drain", bus.rx_valid, 1'b0);
        exp_q.push_back(8'h11);
        check_stream("ovr");

        // Framing error, then a frame that arrives before 16 high ticks.
        fe0 = n_fe; vld0 = n_vld;
        send_byte(8'h55, 1'b0);
        clks(4);
        chk("fe_pulses", n_fe - fe0, 1);
        chk("fe_no_valid", n_vld - vld0, 0);
        send_byte(8'h00, 1'b1);
        clks(20);
        chk("fe_resync_ignored", n_vld - vld0, 0);
        chk("fe_no_more_fe", n_fe - fe0, 1);
        send_byte(8'h66, 1'b1); exp_q.push_back(8'h66);
        clks(8);
        check_stream("fe_then_66");

        // False start: short low glitch.
        fe0 = n_fe; ov0 = n_ov; vld0 = n_vld; busy0 = n_busy;
        rxd = 1'b0;
        clks(4);
        rxd = 1'b1;
        clks(10);
        chk("fs_busy_seen", (n_busy - busy0) > 0, 1'b1);
        chk("fs_busy_clear", bus.busy, 1'b0);
        chk("fs_no_valid", n_vld - vld0, 0);
        chk("fs_no_flags", (n_fe - fe0) + (n_ov - ov0), 0);
        clks(20);

        // Reset mid-frame during 8'h99 (bit1 is low), release while low.
        rxd = 1'b0; clks(16);      // start
        rxd = 1'b1; clks(16);      // bit0
        rxd = 1'b0; clks(8);       // bit1, mid-bit
        rst_n = 1'b0;
        clks(2);
        chk("rst_mid_outputs", {bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.busy}, 32'd0);
        rst_n = 1'b1;
        fe0 = n_fe; ov0 = n_ov; vld0 = n_vld; busy0 = n_busy;
        clks(20);
        rxd = 1'b1; clks(10);      // too short to count as idle
        rxd = 1'b0; clks(20);      // would look like a start if not resyncing
        rxd = 1'b1; clks(20);
        chk("rst_no_busy", n_busy - busy0, 0);
        chk("rst_no_valid", n_vld - vld0, 0);
        chk("rst_no_flags", (n_fe - fe0) + (n_ov - ov0), 0);
        send_byte(8'h99, 1'b1); exp_q.push_back(8'h99);
        clks(8);
        check_stream("rst_then_99");

        chk("flags_exclusive", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
